// File: rtl/shift_pipe_ctrl.sv
// Elastic ready/valid controller for a fixed-latency, enable-gated data delay line.
// Define SHIFT_PIPE_CTRL_STATS_EN to add the saturating stall_cycles counter output.
module shift_pipe_ctrl #(
    parameter int DATAW = 8,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             shift_en,
    output logic [CNTW-1:0]  occupancy,
`ifdef SHIFT_PIPE_CTRL_STATS_EN
    output logic [15:0]      stall_cycles,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    logic [DATAW-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CNTW-1:0]  r_occ;
    state_t           r_state;

    logic             w_stall;
    logic             w_shift;
    logic             w_accept;
    logic             w_remove;
    logic [CNTW-1:0]  w_occ_next;

    // The whole pipe moves as one; bubbles are carried, never squeezed out.
    always_comb begin
        w_stall    = r_valid[DEPTH-1] & ~out_ready;
        w_shift    = ~flush & ~w_stall;
        w_accept   = in_valid & w_shift;
        w_remove   = r_valid[DEPTH-1] & w_shift;
        w_occ_next = r_occ + CNTW'(w_accept) - CNTW'(w_remove);
    end

    assign shift_en  = w_shift;
    assign in_ready  = w_shift;
    assign out_valid = r_valid[DEPTH-1] & ~flush;
    assign out_data  = r_stage[DEPTH-1];
    assign occupancy = r_occ;
    assign state     = r_state;

    // Data is left unreset on purpose; the valid chain alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_stage[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_shift) begin
            r_valid[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ   <= '0;
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_occ   <= '0;
            r_state <= ST_FLUSH;
        end else begin
            r_occ <= w_occ_next;
            if (w_stall) begin
                r_state <= ST_STALL;
            end else if (w_occ_next != '0) begin
                r_state <= ST_RUN;
            end else begin
                r_state <= ST_EMPTY;
            end
        end
    end

`ifdef SHIFT_PIPE_CTRL_STATS_EN
    logic [15:0] r_stall_cnt;

    // Flush deliberately leaves the counter alone so stalls survive pipe clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule
